// File: rtl/eq_pkg.sv
// Shared constants, types and FSM encoding for the equalizer band mixer.
package eq_pkg;
   localparam int NBANDS     = 8;
   localparam int DATA_W     = 16;
   localparam int GAIN_W     = 8;
   localparam int CNT_W      = 16;
   localparam int IDX_W      = $clog2(NBANDS);
   localparam int PROD_W     = DATA_W + GAIN_W;
   localparam int ACC_W      = PROD_W + IDX_W;
   localparam int GAIN_UNITY = 64;
   localparam int GAIN_FRAC  = 6;

   typedef logic signed [DATA_W-1:0] sample_t;
   typedef logic [GAIN_W-1:0]        gain_t;

   typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_SCALE, ST_OUT} state_e;
endpackage

// File: rtl/eq_sat_round.sv
// Drops the Q2.6 gain fraction with round-half-up, then clamps to the signed sample range.
module eq_sat_round #(
   parameter int ACC_W  = 27,
   parameter int DATA_W = 16,
   parameter int FRAC   = 6
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic [DATA_W-1:0]       res,
   output logic                    sat
);
   localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] MINV = -MAXV - ACC_W'(1);

   logic signed [ACC_W-1:0] r;

   // Accumulator headroom guarantees acc + HALF cannot overflow.
   assign r = (acc + HALF) >>> FRAC;

   always_comb begin
      res = r[DATA_W-1:0];
      sat = 1'b0;
      if (r > MAXV) begin
         res = {1'b0, {(DATA_W-1){1'b1}}};
         sat = 1'b1;
      end else if (r < MINV) begin
         res = {1'b1, {(DATA_W-1){1'b0}}};
         sat = 1'b1;
      end
   end
endmodule

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt <= '0;
      else if (inc && cnt != '1) cnt <= cnt + W'(1);
   end
endmodule

// File: rtl/eq_band_mixer.sv
// Serial gain-weighted sum of the equalizer bands, one band per cycle, feeding the DAC FIFO.
module eq_band_mixer #(
   parameter int NBANDS = eq_pkg::NBANDS,
   parameter int DATA_W = eq_pkg::DATA_W,
   parameter int GAIN_W = eq_pkg::GAIN_W,
   parameter int CNT_W  = eq_pkg::CNT_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NBANDS*DATA_W-1:0]   band_in,
   input  logic                       band_valid,
   input  logic [NBANDS*GAIN_W-1:0]   gain_in,
   input  logic                       dacfifo_full,
   output logic [DATA_W-1:0]          eq_out,
   output logic                       dacfifo_write,
   output logic                       busy,
   output logic [CNT_W-1:0]           sat_cnt,
   output logic [CNT_W-1:0]           overrun_cnt,
   output logic [CNT_W-1:0]           drop_cnt
);
   import eq_pkg::*;

   localparam int IW = $clog2(NBANDS);
   localparam int PW = DATA_W + GAIN_W;
   localparam int AW = PW + IW;

   state_e                         state;
   logic [NBANDS-1:0][DATA_W-1:0]  bands_q;
   logic [NBANDS-1:0][GAIN_W-1:0]  gains_q;
   logic [IW-1:0]                  idx;
   logic signed [AW-1:0]           acc;
   logic signed [PW-1:0]           band_x, gain_x, prod;
   logic [DATA_W-1:0]              rnd_res;
   logic                           rnd_sat;

   // Gain is unsigned, so it enters the signed multiply zero-extended.
   assign band_x = PW'($signed(bands_q[idx]));
   assign gain_x = PW'({1'b0, gains_q[idx]});
   assign prod   = band_x * gain_x;

   eq_sat_round #(.ACC_W(AW), .DATA_W(DATA_W), .FRAC(GAIN_FRAC)) u_sat_round (
      .acc (acc),
      .res (rnd_res),
      .sat (rnd_sat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         bands_q <= '0;
         gains_q <= '0;
         idx     <= '0;
         acc     <= '0;
         eq_out  <= '0;
      end else begin
         case (state)
            ST_IDLE: if (band_valid) begin
               bands_q <= band_in;
               gains_q <= gain_in;
               acc     <= '0;
               idx     <= '0;
               state   <= ST_MAC;
            end
            ST_MAC: begin
               acc <= acc + AW'(prod);
               idx <= idx + IW'(1);
               if (idx == IW'(NBANDS - 1)) state <= ST_SCALE;
            end
            ST_SCALE: begin
               // Loaded on entry to OUT so the sample is stable for the whole write cycle.
               eq_out <= rnd_res;
               state  <= ST_OUT;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy          = (state != ST_IDLE);
   assign dacfifo_write = (state == ST_OUT) && !dacfifo_full;

   sat_counter #(.W(CNT_W)) u_sat_cnt (
      .clk(clk), .rst_n(rst_n), .inc(state == ST_SCALE && rnd_sat), .cnt(sat_cnt));
   sat_counter #(.W(CNT_W)) u_overrun_cnt (
      .clk(clk), .rst_n(rst_n), .inc(band_valid && busy), .cnt(overrun_cnt));
   sat_counter #(.W(CNT_W)) u_drop_cnt (
      .clk(clk), .rst_n(rst_n), .inc(state == ST_OUT && dacfifo_full), .cnt(drop_cnt));
endmodule

// File: tb/tb_eq_band_mixer.sv
// Directed checks of mix arithmetic, latency, overrun, FIFO-full drop and reset for eq_band_mixer.
module tb_eq_band_mixer;
   import eq_pkg::*;

   localparam int BW = NBANDS * DATA_W;
   localparam int GW = NBANDS * GAIN_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [BW-1:0]     band_in;
   logic              band_valid;
   logic [GW-1:0]     gain_in;
   logic              dacfifo_full;
   logic [DATA_W-1:0] eq_out;
   logic              dacfifo_write;
   logic              busy;
   logic [CNT_W-1:0]  sat_cnt, overrun_cnt, drop_cnt;

   int checks = 0;
   int failures = 0;

   logic [BW-1:0] bv;
   logic [GW-1:0] gv;

   eq_band_mixer dut (
      .clk(clk), .rst_n(rst_n), .band_in(band_in), .band_valid(band_valid),
      .gain_in(gain_in), .dacfifo_full(dacfifo_full), .eq_out(eq_out),
      .dacfifo_write(dacfifo_write), .busy(busy), .sat_cnt(sat_cnt),
      .overrun_cnt(overrun_cnt), .drop_cnt(drop_cnt));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] fill_b(input int v);
      logic [BW-1:0] r;
      for (int k = 0; k < NBANDS; k++) r[k*DATA_W +: DATA_W] = DATA_W'(v);
      return r;
   endfunction

   function automatic logic [GW-1:0] fill_g(input int v);
      logic [GW-1:0] r;
      for (int k = 0; k < NBANDS; k++) r[k*GAIN_W +: GAIN_W] = GAIN_W'(v);
      return r;
   endfunction

   // Called in cycle T; returns in T+11 with the mixer idle again.
   task automatic run(input string tag, input logic [BW-1:0] b, input logic [GW-1:0] g,
                      input logic full, input int exp_out, input logic exp_wr);
      band_in = b; gain_in = g; band_valid = 1'b1;
      tick();
      band_valid = 1'b0;
      chk({tag, ".busy"}, busy, 1);
      repeat (8) tick();
      chk({tag, ".wr_early"}, dacfifo_write, 0);
      dacfifo_full = full;
      tick();
      chk({tag, ".wr"}, dacfifo_write, exp_wr);
      chk({tag, ".out"}, $signed(eq_out), exp_out);
      tick();
      dacfifo_full = 1'b0;
      chk({tag, ".wr_after"}, dacfifo_write, 0);
      chk({tag, ".idle"}, busy, 0);
   endtask

   initial begin
      rst_n = 1'b0; band_in = '0; gain_in = '0; band_valid = 1'b0; dacfifo_full = 1'b0;
      repeat (3) tick();
      chk("rst.busy", busy, 0);
      chk("rst.out", eq_out, 0);
      chk("rst.wr", dacfifo_write, 0);
      chk("rst.sat", sat_cnt, 0);
      chk("rst.ovr", overrun_cnt, 0);
      chk("rst.drop", drop_cnt, 0);
      rst_n = 1'b1;
      tick();

      run("unity", fill_b(1000), fill_g(GAIN_UNITY), 1'b0, 8000, 1'b1);
      chk("unity.sat", sat_cnt, 0);

      run("sat_pos", fill_b(30000), fill_g(64), 1'b0, 32767, 1'b1);
      chk("sat_pos.cnt", sat_cnt, 1);
      run("sat_neg", fill_b(-30000), fill_g(64), 1'b0, -32768, 1'b1);
      chk("sat_neg.cnt", sat_cnt, 2);

      bv = fill_b(1000); bv[0 +: DATA_W] = 16'sd1;
      gv = fill_g(0);    gv[0 +: GAIN_W] = 8'd32;
      run("rnd_up", bv, gv, 1'b0, 1, 1'b1);
      bv[0 +: DATA_W] = -16'sd1;
      run("rnd_neg", bv, gv, 1'b0, 0, 1'b1);
      bv = fill_b(0); bv[3*DATA_W +: DATA_W] = 16'sd100;
      gv = fill_g(0); gv[3*GAIN_W +: GAIN_W] = 8'd255;
      run("gain_max", bv, gv, 1'b0, 398, 1'b1);
      chk("gain_max.sat", sat_cnt, 2);

      // Overrun: pulses at T+5 and T+10 ignored, gain change at T+3 ignored, T+11 accepted.
      band_in = fill_b(1000); gain_in = fill_g(64); band_valid = 1'b1;
      tick(); band_valid = 1'b0;
      repeat (2) tick(); gain_in = fill_g(0);
      repeat (2) tick(); band_valid = 1'b1;
      tick(); band_valid = 1'b0;
      chk("ovr.cnt1", overrun_cnt, 1);
      repeat (4) tick();
      chk("ovr.wr", dacfifo_write, 1);
      chk("ovr.out", $signed(eq_out), 8000);
      band_valid = 1'b1;
      tick();
      gain_in = fill_g(32);
      chk("ovr.cnt2", overrun_cnt, 2);
      chk("ovr.wr_after", dacfifo_write, 0);
      tick(); band_valid = 1'b0;
      chk("ovr.accept", busy, 1);
      repeat (8) tick();
      chk("ovr2.wr_early", dacfifo_write, 0);
      tick();
      chk("ovr2.wr", dacfifo_write, 1);
      chk("ovr2.out", $signed(eq_out), 4000);
      tick();
      chk("ovr2.cnt", overrun_cnt, 2);

      run("full", fill_b(500), fill_g(64), 1'b1, 4000, 1'b0);
      chk("full.drop", drop_cnt, 1);
      run("notfull", fill_b(2000), fill_g(64), 1'b0, 16000, 1'b1);
      chk("notfull.drop", drop_cnt, 1);

      // Reset in the middle of MAC.
      band_in = fill_b(3000); gain_in = fill_g(64); band_valid = 1'b1;
      tick(); band_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst.busy", busy, 0);
      chk("mid_rst.out", eq_out, 0);
      chk("mid_rst.wr", dacfifo_write, 0);
      chk("mid_rst.sat", sat_cnt, 0);
      chk("mid_rst.ovr", overrun_cnt, 0);
      chk("mid_rst.drop", drop_cnt, 0);
      tick();
      rst_n = 1'b1;
      tick();
      run("post_rst", fill_b(100), fill_g(64), 1'b0, 800, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/eq_band_mixer.md
Name: eq_band_mixer

Overview:
Sums the 8 per-band filter outputs of the equalizer into one 16-bit sample and applies a per-band gain to each band. It uses a serial multiply-accumulate over the bands, then rounds and saturates the result. It sits between the band filter bank (filtered_out[0..7]) and the DAC FIFO, and it drives eq_out and dacfifo_write directly. It also exposes status counters for the GAO probe and for the register interface.

Parameters:
NBANDS, 8, number of bands summed (power of 2)
DATA_W, 16, signed sample width, band inputs and output
GAIN_W, 8, unsigned gain width, Q2.6 format (64 = unity, max 255 ≈ 3.98)
CNT_W, 16, width of the status counters

Ports:
clk  in  1  system clock
rst_n  in  1  reset
band_in  in  NBANDS*DATA_W  signed band samples, band k at bits [k*DATA_W +: DATA_W]
band_valid  in  1  one-cycle strobe: band_in is valid
gain_in  in  NBANDS*GAIN_W  per-band gains, same packing as band_in
dacfifo_full  in  1  DAC FIFO full flag
eq_out  out  DATA_W  mixed sample (signed)
dacfifo_write  out  1  one-cycle write strobe to the DAC FIFO
busy  out  1  high while a sample is in flight
sat_cnt  out  CNT_W  count of saturated outputs, saturating counter
overrun_cnt  out  CNT_W  count of band_valid pulses ignored while busy, saturating counter
drop_cnt  out  CNT_W  count of samples dropped on FIFO full, saturating counter

Behaviour:
- Reset is asynchronous and active-low on rst_n, with one clock, clk.
- Reset values: state=IDLE; eq_out=0, dacfifo_write=0, busy=0; all counters=0; accumulator=0.
- FSM states: IDLE -> MAC -> SCALE -> OUT -> IDLE.
- IDLE:
  - On band_valid, snapshot band_in and gain_in into internal registers.
  - Clear the accumulator and set band index=0; go to MAC.
  - Later changes to gain_in do not affect the sample in flight.
- MAC:
  - Each cycle: acc += band[idx] * $signed({1'b0,gain[idx]}).
  - Product is 24-bit signed; accumulator is DATA_W+GAIN_W+log2(NBANDS) = 27 bits, so it never overflows.
  - Runs NBANDS cycles; after idx=NBANDS-1 go to SCALE.
- SCALE:
  - r = (acc + 32) >>> 6, an arithmetic shift (round half toward +inf).
  - If r > 32767, result = 32767; if r < -32768, result = -32768; in either case sat_cnt++.
  - Go to OUT.
- OUT:
  - Load eq_out with the result.
  - If dacfifo_full=0, pulse dacfifo_write=1 for this cycle only.
  - If dacfifo_full=1, set dacfifo_write=0 and drop_cnt++. eq_out is still updated.
  - Go to IDLE.
- Latency: band_valid sampled high in cycle T → MAC in T+1..T+8 → SCALE in T+9 → eq_out valid and dacfifo_write high in T+10.
- eq_out holds its value until the next OUT.
- busy is high from T+1 through T+10. The minimum band_valid spacing is 11 cycles.
- band_valid while busy=1: ignored and overrun_cnt++. A band_valid in cycle T+10 (OUT) is also ignored; one in T+11 is accepted.
- All counters saturate at 2^CNT_W-1 and never wrap.
- When a saturation and a drop occur on the same sample, both counters increment.
- rst_n asserted mid-operation: state, outputs and counters return immediately to their reset values. No partial write is issued.

Decomposition:
- Package eq_pkg holds the shared constants and typedefs: NBANDS, DATA_W, GAIN_W, ACC_W, GAIN_UNITY=64, GAIN_FRAC=6, the sample_t/gain_t typedefs, and the FSM state enum.
- One sub-module, eq_sat_round, is natural: a combinational unit that takes the ACC_W accumulator and produces the rounded, saturated DATA_W result plus a sat flag.
- One sat_counter instance is reused for each of the three counters.

Test Plan:
- Unity mix: all gains=64, all bands=1000, band_valid at T → eq_out=8000 and dacfifo_write high in exactly cycle T+10, for one cycle; sat_cnt=0.
- Saturation: all gains=64; bands=+30000 → eq_out=32767, sat_cnt=1. Then bands=-30000 → eq_out=-32768, sat_cnt=2.
- Rounding and gain: band0=1, gain0=32, all other gains=0 → eq_out=1. Band0=-1 → eq_out=0. Band3=100 with gain3=255 and others 0 → eq_out=398.
- Overrun and snapshot: band_valid at T and T+5, and gain_in changed at T+3 → one output using the gains captured at T; overrun_cnt=1. A band_valid at T+11 is accepted.
- FIFO full: dacfifo_full=1 during OUT → no dacfifo_write; drop_cnt=1; eq_out updated. Next sample with the FIFO not full → written normally.
- Reset mid-MAC: rst_n low at T+4 → busy=0, eq_out=0, counters=0 immediately. A following band_valid produces a correct result 10 cycles later.
